// File: rtl/baw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : baw_pkg
// Description : Shared constants for the push-button front end: channel
//               indices of the five board buttons and the short debounce
//               length used by simulation benches.
// Revision    : 1.0 - initial release
// ============================================================================
package baw_pkg;

  localparam int BTN_CENTER          = 0;
  localparam int BTN_TOP             = 1;
  localparam int BTN_BOTTOM          = 2;
  localparam int BTN_LEFT            = 3;
  localparam int BTN_RIGHT           = 4;
  localparam int NUM_BTN             = 5;

  // Short debounce length so benches finish in a handful of cycles.
  localparam int DEBOUNCE_CYCLES_SIM = 4;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : One button channel: 2-flop synchronizer, run-length debounce
//               counter, debounced level and one-cycle press/release pulses.
// Ports       : clk          in   system clock, rising edge
//               reset_n      in   asynchronous active-low reset
//               btn_raw      in   raw asynchronous pad, 1 = pressed
//               btn_level    out  debounced level
//               btn_press    out  one-cycle pulse on level 0->1
//               btn_release  out  one-cycle pulse on level 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  import baw_pkg::*;

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q,      s1_d;
  logic             s2_q,      s2_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             level_q,   level_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;

  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    // The counter holds how long s2 has disagreed with the accepted level;
    // any agreement restarts the run, so bounces never accumulate.
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d   = s2_q;
        press_d   = s2_q;
        release_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner
// Description : Front end for the board push-buttons. Debounces every
//               channel and presents a one-hot, priority-filtered press
//               event so the game FSM sees at most one press per clock.
// Ports       : clk          in   system clock, rising edge
//               reset_n      in   asynchronous active-low reset
//               btn_raw      in   [NUM_BTN] raw pads, 1 = pressed
//               btn_level    out  [NUM_BTN] debounced levels
//               btn_press    out  [NUM_BTN] one-cycle press pulses
//               btn_release  out  [NUM_BTN] one-cycle release pulses
//               btn_evt      out  [NUM_BTN] lowest-index press only
//               any_press    out  OR of btn_press
// Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
  parameter int NUM_BTN         = baw_pkg::NUM_BTN,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_evt,
  output logic               any_press
);

  import baw_pkg::*;

  logic press_seen;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_raw     (btn_raw[gi]),
      .btn_level   (btn_level[gi]),
      .btn_press   (btn_press[gi]),
      .btn_release (btn_release[gi])
    );
  end

  // Lowest index wins; losing simultaneous presses are dropped, not queued.
  always_comb begin
    btn_evt    = '0;
    press_seen = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_press[i] && !press_seen) begin
        btn_evt[i] = 1'b1;
        press_seen = 1'b1;
      end
    end
  end

  assign any_press = |btn_press;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_conditioner
// Description : Self-checking bench for btn_conditioner with a 4-cycle
//               debounce. Expected pulse cycles are queued when stimulus is
//               driven and compared when that cycle arrives; every other
//               cycle must be pulse-free.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

  localparam int DEB = baw_pkg::DEBOUNCE_CYCLES_SIM;
  // Drive at the falling edge after edge E: sampled at E+1, two sync edges,
  // then DEB counting edges -> visible after edge E+DEB+2.
  localparam int LAT = DEB + 2;

  typedef struct {
    int         cyc;
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] evt;
    logic       any;
    logic [4:0] level;
  } exp_t;

  typedef struct {
    logic [4:0] pat;
    logic [4:0] evt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] btn_raw;
  logic [4:0] btn_level, btn_press, btn_release, btn_evt;
  logic       any_press;

  int   edge_n   = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[7];

  btn_conditioner #(
    .NUM_BTN         (5),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_evt     (btn_evt),
    .any_press   (any_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void push(input int c, input logic [4:0] p, input logic [4:0] r,
                               input logic [4:0] e, input logic a, input logic [4:0] l);
    exp_t x;
    x.cyc = c; x.press = p; x.rel = r; x.evt = e; x.any = a; x.level = l;
    sb.push_back(x);
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from state changes.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == edge_n) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (btn_press !== e.press || btn_release !== e.rel || btn_evt !== e.evt ||
          any_press !== e.any || btn_level !== e.level) begin
        failures++;
        $display("FAIL event@%0d press=%b/%b release=%b/%b evt=%b/%b any=%b/%b level=%b/%b (got/exp)",
                 edge_n, btn_press, e.press, btn_release, e.rel, btn_evt, e.evt,
                 any_press, e.any, btn_level, e.level);
      end
    end else begin
      checks++;
      if ((btn_press | btn_release | btn_evt) !== 5'b0 || any_press !== 1'b0) begin
        failures++;
        $display("FAIL idle@%0d press=%b release=%b evt=%b any=%b (exp all 0)",
                 edge_n, btn_press, btn_release, btn_evt, any_press);
      end
    end
  end

  task automatic check_level(input string name, input logic [4:0] exp);
    checks++;
    if (btn_level !== exp) begin
      failures++;
      $display("FAIL %s level=%b exp=%b", name, btn_level, exp);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_evt, any_press} !== 21'b0) begin
      failures++;
      $display("FAIL %s level=%b press=%b release=%b evt=%b any=%b exp all 0",
               name, btn_level, btn_press, btn_release, btn_evt, any_press);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{pat: 5'b00010, evt: 5'b00010};
    vecs[1] = '{pat: 5'b10001, evt: 5'b00001};
    vecs[2] = '{pat: 5'b10000, evt: 5'b10000};
    vecs[3] = '{pat: 5'b01100, evt: 5'b00100};
    vecs[4] = '{pat: 5'b11110, evt: 5'b00010};
    vecs[5] = '{pat: 5'b11111, evt: 5'b00001};
    vecs[6] = '{pat: 5'b01000, evt: 5'b01000};

    reset_n = 1'b0;
    btn_raw = 5'b0;
    cycles(3);
    check_zero("reset_state");
    reset_n = 1'b1;
    cycles(3);

    // Clean presses and releases, single and simultaneous.
    for (int i = 0; i < 7; i++) begin
      btn_raw = vecs[i].pat;
      push(edge_n + LAT, vecs[i].pat, 5'b0, vecs[i].evt, 1'b1, vecs[i].pat);
      cycles(10);
      check_level("held", vecs[i].pat);
      btn_raw = 5'b0;
      push(edge_n + LAT, 5'b0, vecs[i].pat, 5'b0, 1'b0, 5'b0);
      cycles(10);
      check_level("released", 5'b0);
    end

    // Bounce on left: 2-cycle runs never reach the count.
    for (int i = 0; i < 6; i++) begin
      btn_raw[3] = (i % 2 == 0);
      cycles(2);
    end
    check_level("bounce", 5'b0);
    btn_raw[3] = 1'b1;
    push(edge_n + LAT, 5'b01000, 5'b0, 5'b01000, 1'b1, 5'b01000);
    cycles(10);
    btn_raw[3] = 1'b0;
    push(edge_n + LAT, 5'b0, 5'b01000, 5'b0, 1'b0, 5'b0);
    cycles(10);

    // Release with a 3-cycle low glitch (one short of the debounce length).
    btn_raw[2] = 1'b1;
    push(edge_n + LAT, 5'b00100, 5'b0, 5'b00100, 1'b1, 5'b00100);
    cycles(10);
    btn_raw[2] = 1'b0;
    cycles(3);
    btn_raw[2] = 1'b1;
    cycles(10);
    check_level("glitch", 5'b00100);
    btn_raw[2] = 1'b0;
    push(edge_n + LAT, 5'b0, 5'b00100, 5'b0, 1'b0, 5'b0);
    cycles(10);

    // Reset mid-debounce with another channel already high.
    btn_raw[4] = 1'b1;
    push(edge_n + LAT, 5'b10000, 5'b0, 5'b10000, 1'b1, 5'b10000);
    cycles(10);
    check_level("pre_reset", 5'b10000);
    btn_raw[1] = 1'b1;
    cycles(2);
    #2;
    btn_raw = 5'b0;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    cycles(2);
    reset_n = 1'b1;
    cycles(20);
    check_level("post_reset", 5'b0);

    // Center held across reset release: one press after normal latency.
    reset_n = 1'b0;
    btn_raw = 5'b00001;
    cycles(3);
    reset_n = 1'b1;
    push(edge_n + LAT, 5'b00001, 5'b0, 5'b00001, 1'b1, 5'b00001);
    cycles(20);
    check_level("held_reset", 5'b00001);
    btn_raw = 5'b0;
    push(edge_n + LAT, 5'b0, 5'b00001, 5'b0, 1'b0, 5'b0);
    cycles(10);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
